lbm_stream_sched: RTL and testbench

- Sequencer for one D2Q9 lattice-Boltzmann time step over an NX x NY grid.
- Per node: first requests a collision from the collision datapath, then issues 9 streaming write commands, one per direction.
- Each command carries the source node address and the destination address, computed from the D2Q9 velocity set (cx, cy in {-1, 0, +1}).
- Sits between the top-level step control and the distribution-function memory/collision units.

---
 rtl/lbm_pkg.sv | 40 ++++
 rtl/lbm_nbr_addr.sv | 60 ++++++
 rtl/lbm_stream_sched.sv | 159 +++++++++++++++
 tb/tb_lbm_stream_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lbm_pkg.sv
// D2Q9 lattice constants and FSM state type shared by the streaming scheduler.
// Optional build macro used by the scheduler slice: LBM_BOUNCE_BACK_EN.
package lbm_pkg;

  localparam int unsigned Q = 9;

  // Velocity set order: 0 (0,0), 1 (1,0), 2 (0,1), 3 (-1,0), 4 (0,-1),
  // 5 (1,1), 6 (-1,1), 7 (-1,-1), 8 (1,-1).
  localparam logic signed [1:0] CX [0:Q-1] = '{
    2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd0, 2'sd1, -2'sd1, -2'sd1, 2'sd1
  };
  localparam logic signed [1:0] CY [0:Q-1] = '{
    2'sd0, 2'sd0, 2'sd1, 2'sd0, -2'sd1, 2'sd1, 2'sd1, -2'sd1, -2'sd1
  };
  localparam logic [3:0] OPP [0:Q-1] = '{
    4'd0, 4'd3, 4'd4, 4'd1, 4'd2, 4'd7, 4'd8, 4'd5, 4'd6
  };

  typedef enum logic [2:0] {
    StIdle,
    StCollide,
    StStream,
    StAdv,
    StFin
  } state_e;

  // Table lookups guarded so unused direction codes 9..15 read as rest/self.
  function automatic logic signed [1:0] cx_of(input logic [3:0] dir);
    return (dir < 4'(Q)) ? CX[dir] : 2'sd0;
  endfunction

  function automatic logic signed [1:0] cy_of(input logic [3:0] dir);
    return (dir < 4'(Q)) ? CY[dir] : 2'sd0;
  endfunction

  function automatic logic [3:0] opp_of(input logic [3:0] dir);
    return (dir < 4'(Q)) ? OPP[dir] : dir;
  endfunction

endpackage

// File: rtl/lbm_nbr_addr.sv
// Combinational D2Q9 neighbour address: (x, y, dir) -> destination node and slot.
// Periodic in both axes; with LBM_BOUNCE_BACK_EN defined, rows 0 and NY-1 are
// solid walls and out-of-grid y moves reflect into the source node.
module lbm_nbr_addr
  import lbm_pkg::*;
#(
  parameter int unsigned NX = 8,
  parameter int unsigned NY = 8,
  parameter int unsigned AW = $clog2(NX * NY),
  parameter int unsigned XW = $clog2(NX),
  parameter int unsigned YW = $clog2(NY)
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [3:0]    dir_i,
  output logic [AW-1:0] dst_o,
  output logic [3:0]    dst_dir_o
);

  logic signed [1:0] cx;
  logic signed [1:0] cy;
  logic [XW-1:0]     dx;
  logic [YW-1:0]     dy;
  logic              wall;

  // Wrap by compare-and-select, then pick reflected or streamed destination.
  always_comb begin
    cx = cx_of(dir_i);
    cy = cy_of(dir_i);

    dx = x_i;
    if (cx == 2'sd1) begin
      dx = (x_i == XW'(NX - 1)) ? '0 : x_i + XW'(1);
    end else if (cx == -2'sd1) begin
      dx = (x_i == '0) ? XW'(NX - 1) : x_i - XW'(1);
    end

    dy = y_i;
    if (cy == 2'sd1) begin
      dy = (y_i == YW'(NY - 1)) ? '0 : y_i + YW'(1);
    end else if (cy == -2'sd1) begin
      dy = (y_i == '0) ? YW'(NY - 1) : y_i - YW'(1);
    end

`ifdef LBM_BOUNCE_BACK_EN
    wall = ((cy == -2'sd1) && (y_i == '0)) || ((cy == 2'sd1) && (y_i == YW'(NY - 1)));
`else
    wall = 1'b0;
`endif

    if (wall) begin
      dst_o     = AW'(y_i) * AW'(NX) + AW'(x_i);
      dst_dir_o = opp_of(dir_i);
    end else begin
      dst_o     = AW'(dy) * AW'(NX) + AW'(dx);
      dst_dir_o = dir_i;
    end
  end

endmodule

// File: rtl/lbm_stream_sched.sv
// One D2Q9 lattice-Boltzmann time step sequencer: per node a collision request,
// then nine streaming write commands. Optional macro: LBM_BOUNCE_BACK_EN
// (wall rows at y = 0 and y = NY-1, handled inside lbm_nbr_addr).
module lbm_stream_sched
  import lbm_pkg::*;
#(
  parameter int unsigned NX = 8,
  parameter int unsigned NY = 8,
  parameter int unsigned AW = $clog2(NX * NY),
  parameter int unsigned SW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          col_req,
  input  logic          col_ack,
  output logic [AW-1:0] cur_addr,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [3:0]    wr_dir,
  output logic [AW-1:0] wr_dst,
  output logic [3:0]    wr_dst_dir,
  output logic [SW-1:0] step_count
);

  localparam int unsigned XW = $clog2(NX);
  localparam int unsigned YW = $clog2(NY);

  state_e        state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [3:0]    dir_q;
  logic [3:0]    dir_d;
  logic          busy_q;
  logic          done_q;
  logic          col_req_q;
  logic [AW-1:0] cur_addr_q;
  logic          wr_valid_q;
  logic [AW-1:0] wr_dst_q;
  logic [3:0]    wr_dst_dir_q;
  logic [SW-1:0] step_count_q;
  logic [AW-1:0] nbr_dst;
  logic [3:0]    nbr_dst_dir;
  logic          last_node;

  assign last_node = (x_q == XW'(NX - 1)) && (y_q == YW'(NY - 1));

  // Direction for the next cycle; the command registers are loaded from it so
  // the next command is ready right after a handshake.
  always_comb begin
    dir_d = '0;
    if (state_q == StStream) begin
      dir_d = dir_q;
      if (wr_ready && (dir_q != 4'(Q - 1))) begin
        dir_d = dir_q + 4'd1;
      end
    end
  end

  lbm_nbr_addr #(
    .NX(NX),
    .NY(NY),
    .AW(AW),
    .XW(XW),
    .YW(YW)
  ) u_nbr (
    .x_i      (x_q),
    .y_i      (y_q),
    .dir_i    (dir_d),
    .dst_o    (nbr_dst),
    .dst_dir_o(nbr_dst_dir)
  );

  // Step FSM with all outputs registered.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      dir_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      col_req_q    <= 1'b0;
      cur_addr_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_dst_q     <= '0;
      wr_dst_dir_q <= '0;
      step_count_q <= '0;
    end else begin
      done_q       <= 1'b0;
      dir_q        <= dir_d;
      wr_dst_q     <= nbr_dst;
      wr_dst_dir_q <= nbr_dst_dir;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StCollide;
            x_q        <= '0;
            y_q        <= '0;
            cur_addr_q <= '0;
            busy_q     <= 1'b1;
            col_req_q  <= 1'b1;
          end
        end
        StCollide: begin
          if (col_ack) begin
            col_req_q  <= 1'b0;
            wr_valid_q <= 1'b1;
            state_q    <= StStream;
          end
        end
        StStream: begin
          if (wr_ready && (dir_q == 4'(Q - 1))) begin
            wr_valid_q <= 1'b0;
            state_q    <= StAdv;
          end
        end
        StAdv: begin
          if (last_node) begin
            x_q        <= '0;
            y_q        <= '0;
            cur_addr_q <= '0;
            state_q    <= StFin;
          end else begin
            if (x_q == XW'(NX - 1)) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
            cur_addr_q <= cur_addr_q + AW'(1);
            col_req_q  <= 1'b1;
            state_q    <= StCollide;
          end
        end
        StFin: begin
          done_q       <= 1'b1;
          step_count_q <= step_count_q + SW'(1);
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign col_req    = col_req_q;
  assign cur_addr   = cur_addr_q;
  assign wr_valid   = wr_valid_q;
  assign wr_dir     = dir_q;
  assign wr_dst     = wr_dst_q;
  assign wr_dst_dir = wr_dst_dir_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_lbm_stream_sched.sv
// Directed bench for lbm_stream_sched on a 4x3 lattice. Honours LBM_BOUNCE_BACK_EN
// for the expected destinations.
module tb_lbm_stream_sched;

  localparam int unsigned NX = 4;
  localparam int unsigned NY = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned SW = 16;

  localparam int CXT [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int CYT [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};
  localparam int OPT [9] = '{0, 3, 4, 1, 2, 7, 8, 5, 6};

  logic          Clk;
  logic          Reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          col_req;
  logic          col_ack;
  logic [AW-1:0] cur_addr;
  logic          wr_valid;
  logic          wr_ready;
  logic [3:0]    wr_dir;
  logic [AW-1:0] wr_dst;
  logic [3:0]    wr_dst_dir;
  logic [SW-1:0] step_count;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int xfer_cnt  = 0;
  int node0_cnt = 0;
  int exp_dir   = 0;
  int exp_node  = 0;
  int spot_dst [4] = '{99, 99, 99, 99};
  int spot_dir [4] = '{99, 99, 99, 99};
  int base;

  lbm_stream_sched #(
    .NX(NX),
    .NY(NY),
    .AW(AW),
    .SW(SW)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .col_req   (col_req),
    .col_ack   (col_ack),
    .cur_addr  (cur_addr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_dir    (wr_dir),
    .wr_dst    (wr_dst),
    .wr_dst_dir(wr_dst_dir),
    .step_count(step_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_dst(input int x, input int y, input int d);
`ifdef LBM_BOUNCE_BACK_EN
    if ((y == 0 && CYT[d] == -1) || (y == NY - 1 && CYT[d] == 1)) return y * NX + x;
`endif
    return ((y + CYT[d] + NY) % NY) * NX + ((x + CXT[d] + NX) % NX);
  endfunction

  function automatic int model_dir(input int y, input int d);
`ifdef LBM_BOUNCE_BACK_EN
    if ((y == 0 && CYT[d] == -1) || (y == NY - 1 && CYT[d] == 1)) return OPT[d];
`endif
    return d;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic start_step();
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_done(input int limit);
    while (done !== 1'b1 && cyc < limit) tick();
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_col_req"}, 32'(col_req), 0);
    chk({pfx, "_cur_addr"}, 32'(cur_addr), 0);
    chk({pfx, "_wr_valid"}, 32'(wr_valid), 0);
    chk({pfx, "_wr_dir"}, 32'(wr_dir), 0);
    chk({pfx, "_wr_dst"}, 32'(wr_dst), 0);
    chk({pfx, "_wr_dst_dir"}, 32'(wr_dst_dir), 0);
    chk({pfx, "_step_count"}, 32'(step_count), 0);
  endtask

  // Transfer scoreboard: sampled on the falling edge, ahead of the handshake edge.
  task automatic monitor();
    int x;
    int y;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        exp_dir  = 0;
        exp_node = 0;
      end else if (start && !busy) begin
        exp_dir   = 0;
        exp_node  = 0;
        node0_cnt = 0;
      end else if (wr_valid && wr_ready) begin
        x = int'(cur_addr) % NX;
        y = int'(cur_addr) / NX;
        chk("node_seq", 32'(cur_addr), exp_node);
        chk("dir_seq", 32'(wr_dir), exp_dir);
        chk("dst", 32'(wr_dst), model_dst(x, y, int'(wr_dir)));
        chk("dst_dir", 32'(wr_dst_dir), model_dir(y, int'(wr_dir)));
        xfer_cnt++;
        if (cur_addr == 0) node0_cnt++;
        if (cur_addr == 0 && wr_dir == 7) begin spot_dst[0] = wr_dst; spot_dir[0] = wr_dst_dir; end
        if (cur_addr == 11 && wr_dir == 5) begin spot_dst[1] = wr_dst; spot_dir[1] = wr_dst_dir; end
        if (cur_addr == 1 && wr_dir == 4) begin spot_dst[2] = wr_dst; spot_dir[2] = wr_dst_dir; end
        if (cur_addr == 9 && wr_dir == 6) begin spot_dst[3] = wr_dst; spot_dir[3] = wr_dst_dir; end
        if (exp_dir == 8) begin
          exp_dir = 0;
          exp_node++;
        end else begin
          exp_dir++;
        end
      end
    end
  endtask

  initial begin
    Reset    = 1'b1;
    start    = 1'b0;
    col_ack  = 1'b1;
    wr_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    #1 Reset = 1'b0;
    #2;
    chk_idle("rst");
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Full step with zero-wait handshakes
    base = xfer_cnt;
    start_step();
    chk("s1_busy", 32'(busy), 1);
    chk("s1_col_req", 32'(col_req), 1);
    chk("s1_cur_addr", 32'(cur_addr), 0);
    wait_done(400);
    chk("s1_latency", cyc, 133);
    chk("s1_xfers", xfer_cnt - base, 108);
    chk("s1_step_count", 32'(step_count), 1);
    chk("s1_busy_end", 32'(busy), 0);
    tick();
    chk("s1_done_pulse", 32'(done), 0);
    start = 1'b1;  // start while idle is handled below; here check a clean idle first
    start = 1'b0;
`ifdef LBM_BOUNCE_BACK_EN
    chk("spot_00_d7_dst", spot_dst[0], 0);
    chk("spot_00_d7_dir", spot_dir[0], 5);
    chk("spot_32_d5_dst", spot_dst[1], 11);
    chk("spot_32_d5_dir", spot_dir[1], 7);
    chk("spot_10_d4_dst", spot_dst[2], 1);
    chk("spot_10_d4_dir", spot_dir[2], 2);
    chk("spot_12_d6_dst", spot_dst[3], 9);
    chk("spot_12_d6_dir", spot_dir[3], 8);
`else
    chk("spot_00_d7_dst", spot_dst[0], 11);
    chk("spot_00_d7_dir", spot_dir[0], 7);
    chk("spot_32_d5_dst", spot_dst[1], 0);
    chk("spot_32_d5_dir", spot_dir[1], 5);
    chk("spot_10_d4_dst", spot_dst[2], 9);
    chk("spot_10_d4_dir", spot_dir[2], 4);
    chk("spot_12_d6_dst", spot_dst[3], 0);
    chk("spot_12_d6_dir", spot_dir[3], 6);
`endif

    // Back-pressure: wr_ready low for 5 cycles on node 0, dir 4
    base = xfer_cnt;
    start_step();
    while (!(wr_valid && wr_dir == 4) && cyc < 60) tick();
    chk("st_dir4_at", cyc, 5);
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_valid", 32'(wr_valid), 1);
      chk("st_dir", 32'(wr_dir), 4);
`ifdef LBM_BOUNCE_BACK_EN
      chk("st_dst", 32'(wr_dst), 0);
      chk("st_dst_dir", 32'(wr_dst_dir), 2);
`else
      chk("st_dst", 32'(wr_dst), 8);
      chk("st_dst_dir", 32'(wr_dst_dir), 4);
`endif
    end
    wr_ready = 1'b1;
    // A start while busy must be dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400);
    chk("st_latency", cyc, 138);
    chk("st_node0_xfers", node0_cnt, 9);
    chk("st_xfers", xfer_cnt - base, 108);
    chk("st_step_count", 32'(step_count), 2);
    tick();

    // Delayed collision ack, then a spurious ack during streaming
    col_ack = 1'b0;
    base = xfer_cnt;
    start_step();
    for (int i = 0; i < 4; i++) begin
      chk("ack_col_req", 32'(col_req), 1);
      chk("ack_no_valid", 32'(wr_valid), 0);
      if (i == 3) col_ack = 1'b1;
      tick();
    end
    chk("ack_col_req_low", 32'(col_req), 0);
    chk("ack_valid", 32'(wr_valid), 1);
    chk("ack_dir0", 32'(wr_dir), 0);
    col_ack = 1'b0;
    tick();
    col_ack = 1'b1;
    tick();
    chk("spur_dir", 32'(wr_dir), 2);
    chk("spur_col_req", 32'(col_req), 0);
    chk("spur_valid", 32'(wr_valid), 1);
    wait_done(400);
    chk("ack_latency", cyc, 136);
    chk("ack_xfers", xfer_cnt - base, 108);
    chk("ack_step_count", 32'(step_count), 3);
    tick();

    // Asynchronous reset at the 50th transfer, then a clean restart
    base = xfer_cnt;
    start_step();
    while ((xfer_cnt - base) < 50 && cyc < 200) tick();
    chk("rs_xfers", xfer_cnt - base, 50);
    #2 Reset = 1'b0;
    #1;
    chk_idle("rs_async");
    tick();
    Reset = 1'b1;
    tick();
    chk("rs_busy", 32'(busy), 0);
    chk("rs_step_count", 32'(step_count), 0);
    base = xfer_cnt;
    start_step();
    chk("rs2_cur_addr", 32'(cur_addr), 0);
    chk("rs2_col_req", 32'(col_req), 1);
    wait_done(400);
    chk("rs2_latency", cyc, 133);
    chk("rs2_xfers", xfer_cnt - base, 108);
    chk("rs2_step_count", 32'(step_count), 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
